decode_stage: RTL
=================

# decode_stage

Registered RV32I/RV32E instruction decode stage with valid/ready handshakes on both sides, a 2-entry skid buffer and flush support. It sits between fetch and register-read/execute. It decodes fields, selects the immediate format from the opcode internally (no external format select), and flags illegal instructions, including register indices outside the configured register file.

## Interface
- XLEN, 32: datapath width of `in_pc`, `out_pc` and `out_imm`. Immediates sign-extend to XLEN.
- NUM_REGS, 16: architectural register count. 16 gives RV32E, 32 gives RV32I.
- REG_W, $clog2(NUM_REGS): width of the register index outputs. Derived; not overridden.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered and in-flight instructions.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of `in_instr`.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  downstream accepts.
- out_pc  out  XLEN  PC, passed through.
- out_opcode  out  7  instr[6:0].
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_rs1  out  REG_W  low REG_W bits of instr[19:15].
- out_rs2  out  REG_W  low REG_W bits of instr[24:20].
- out_rd  out  REG_W  low REG_W bits of instr[11:7].
- out_fmt  out  3  instruction format: 0=I, 1=S, 2=B, 3=U, 4=J, 5=R.
- out_imm  out  XLEN  sign-extended immediate. 0 for R format.
- out_illegal  out  1  instruction is illegal; all other fields are still populated.

## Operation
- Format selection by opcode:
  - 0110111 LUI and 0010111 AUIPC: U.
  - 1101111 JAL: J.
  - 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 0001111 MISC-MEM, 1110011 SYSTEM: I.
  - 0100011 STORE: S.
  - 1100011 BRANCH: B.
  - 0110011 OP: R.
  - Any other opcode: fmt R, imm 0, illegal=1.
- Immediate construction:
  - I: sign(instr[31:20]).
  - S: sign({instr[31:25], instr[11:7]}).
  - B: sign({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U: {instr[31:12], 12'b0}, sign-extended to XLEN.
  - J: sign({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- Register-index check: illegal is also set when any register used by the format has an index ≥ NUM_REGS.
  - R, S, B check rs1 and rs2.
  - I checks rs1.
  - R, I, U, J check rd.
  - This check never fires when NUM_REGS=32.
- Illegal encoding: instr[1:0] ≠ 2'b11 also sets illegal.
- Decode is combinational from the input. Results are captured into an output register (entry O) plus a skid register (entry S).
- Buffer rules:
  - `in_ready` = !S_valid.
  - Accept on in_valid && in_ready.
  - If O is empty, or O is draining this cycle (out_valid && out_ready), the accepted item goes to O (from S first if S is valid). Otherwise it goes to S.
  - When O drains and S is valid, S moves to O and S empties.
  - Order is strictly FIFO. No item is dropped or duplicated.
- Flush has priority over everything. O_valid and S_valid clear next cycle, and the input offered in the flush cycle is not accepted.

## Timing
- Reset state: out_valid=0, S_valid=0, every out_* data field 0, out_illegal=0.
  - in_ready=0 while rst is high; in_ready=1 the first cycle after rst deasserts.
- Latency: an instruction accepted at edge N is presented on out_* after edge N, i.e. one cycle.
- Throughput: 1 instruction/cycle while out_ready is held high.
- in_ready depends only on registered state, never combinationally on out_ready.
- Output stability: while out_valid && !out_ready, all out_* fields hold constant.
- Full condition: O and S both valid, so in_ready=0. The first cycle out_ready=1 drains O; in_ready returns to 1 the following cycle.
- Flush or rst mid-stream: the pipeline is empty the next cycle. An output handshake in the flush cycle still counts as consumed downstream.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, all out_* fields 0, in_ready=0; after release, in_ready=1 and nothing is emitted.
- Immediates, out_ready=1, NUM_REGS=16:
  - 0xFFF10093 -> fmt 0, rd 1, rs1 2, imm 0xFFFFFFFF.
  - 0x00512423 -> fmt 1, imm 8.
  - 0xFFDFF0EF -> fmt 4, imm 0xFFFFFFFC.
  - 0x123451B7 -> fmt 3, imm 0x12345000.
  - Each appears one cycle after acceptance, with illegal=0.
- Illegal detection, NUM_REGS=16:
  - 0x00000833 (rd=16) -> illegal=1.
  - 0x0000007F -> illegal=1, fmt 5, imm 0.
  - 0x00000833 with NUM_REGS=32 -> illegal=0.
- Backpressure: out_ready=0, offer A, B, C back-to-back -> A in O, B in S, in_ready=0 and C held. Raise out_ready -> A, B, C emerge in order on consecutive cycles with no loss.
- Flush: O and S full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed and offered items never appear.
- Random stress: random in_valid/out_ready/flush against a reference queue model -> sequence matches and fields are stable while stalled.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV32E decode with a two-entry skid buffer.
// Decode is combinational from the input. Results land in an output entry (O)
// and a skid entry (S). Flush empties both.
module decode_stage #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned REG_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [6:0]        out_opcode,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic [REG_W-1:0]  out_rs1,
    output logic [REG_W-1:0]  out_rs2,
    output logic [REG_W-1:0]  out_rd,
    output logic [2:0]        out_fmt,
    output logic [XLEN-1:0]   out_imm,
    output logic              out_illegal
);

    localparam int unsigned IDX_W = 6;

    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_U = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;
    localparam logic [2:0] FMT_R = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [2:0]       fmt;
        logic [XLEN-1:0]  imm;
        logic             illegal;
    } dec_t;

    dec_t        dec_d;
    dec_t        o_q;
    dec_t        s_q;
    logic        o_valid;
    logic        s_valid;

    logic [31:0] imm32;
    logic        bad_opcode;
    logic        use_rs1;
    logic        use_rs2;
    logic        use_rd;
    logic        bad_reg;

    logic        drain;
    logic        accept;
    logic        o_valid_d;
    logic        s_valid_d;
    logic        load_o_from_s;
    logic        load_o_from_in;
    logic        load_s;

    // Field extraction, format/immediate selection and legality check.
    always_comb begin
        dec_d      = '0;
        imm32      = '0;
        bad_opcode = 1'b0;
        dec_d.fmt  = FMT_R;

        case (in_instr[6:0])
            7'b0110111, 7'b0010111: begin
                dec_d.fmt = FMT_U;
                imm32     = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_d.fmt = FMT_J;
                imm32     = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                             in_instr[30:21], 1'b0};
            end
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin
                dec_d.fmt = FMT_I;
                imm32     = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                dec_d.fmt = FMT_S;
                imm32     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_d.fmt = FMT_B;
                imm32     = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                             in_instr[11:8], 1'b0};
            end
            7'b0110011: dec_d.fmt = FMT_R;
            default:    bad_opcode = 1'b1;
        endcase

        use_rs1 = (dec_d.fmt == FMT_R) || (dec_d.fmt == FMT_S) ||
                  (dec_d.fmt == FMT_B) || (dec_d.fmt == FMT_I);
        use_rs2 = (dec_d.fmt == FMT_R) || (dec_d.fmt == FMT_S) ||
                  (dec_d.fmt == FMT_B);
        use_rd  = (dec_d.fmt == FMT_R) || (dec_d.fmt == FMT_I) ||
                  (dec_d.fmt == FMT_U) || (dec_d.fmt == FMT_J);

        // Indices are compared in full 5 bits so RV32E catches x16..x31.
        bad_reg = (use_rs1 && ({1'b0, in_instr[19:15]} >= IDX_W'(NUM_REGS))) ||
                  (use_rs2 && ({1'b0, in_instr[24:20]} >= IDX_W'(NUM_REGS))) ||
                  (use_rd  && ({1'b0, in_instr[11:7]}  >= IDX_W'(NUM_REGS)));

        dec_d.pc      = in_pc;
        dec_d.opcode  = in_instr[6:0];
        dec_d.funct3  = in_instr[14:12];
        dec_d.funct7  = in_instr[31:25];
        dec_d.rs1     = in_instr[15 +: REG_W];
        dec_d.rs2     = in_instr[20 +: REG_W];
        dec_d.rd      = in_instr[7 +: REG_W];
        dec_d.imm     = XLEN'($signed(imm32));
        dec_d.illegal = bad_opcode || bad_reg || (in_instr[1:0] != 2'b11);
    end

    // Skid-buffer next state: O refills from S first, else from the input.
    always_comb begin
        drain          = o_valid && out_ready;
        accept         = in_valid && in_ready && !flush;
        o_valid_d      = o_valid;
        s_valid_d      = s_valid;
        load_o_from_s  = 1'b0;
        load_o_from_in = 1'b0;
        load_s         = 1'b0;

        if (flush) begin
            o_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!o_valid || drain) begin
            if (s_valid) begin
                load_o_from_s = 1'b1;
                o_valid_d     = 1'b1;
                s_valid_d     = 1'b0;
            end else if (accept) begin
                load_o_from_in = 1'b1;
                o_valid_d      = 1'b1;
            end else begin
                o_valid_d = 1'b0;
            end
        end else if (accept) begin
            load_s    = 1'b1;
            s_valid_d = 1'b1;
        end
    end

    // Buffer registers; in_ready is registered as the inverse of next S_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid  <= 1'b0;
            s_valid  <= 1'b0;
            in_ready <= 1'b0;
            o_q      <= '0;
            s_q      <= '0;
        end else begin
            o_valid  <= o_valid_d;
            s_valid  <= s_valid_d;
            in_ready <= !s_valid_d;
            if (load_o_from_s) begin
                o_q <= s_q;
            end
            if (load_o_from_in) begin
                o_q <= dec_d;
            end
            if (load_s) begin
                s_q <= dec_d;
            end
        end
    end

    assign out_valid   = o_valid;
    assign out_pc      = o_q.pc;
    assign out_opcode  = o_q.opcode;
    assign out_funct3  = o_q.funct3;
    assign out_funct7  = o_q.funct7;
    assign out_rs1     = o_q.rs1;
    assign out_rs2     = o_q.rs2;
    assign out_rd      = o_q.rd;
    assign out_fmt     = o_q.fmt;
    assign out_imm     = o_q.imm;
    assign out_illegal = o_q.illegal;

endmodule
